// File: rtl/sweeper_pkg.sv
// ============================================================================
// sweeper_pkg : shared types and sizing helpers for truth_table_sweeper
// Rev 1.0
// ============================================================================
`default_nettype none

package sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Dwell counter must represent 0..DWELL without wrapping inside a dwell.
  function automatic int cnt_width(input int dwell);
    return $clog2(dwell + 1);
  endfunction

  function automatic int tt_width(input int n_in);
    return 2 ** n_in;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dwell_counter.sv
// ============================================================================
// dwell_counter : counts clocks within one vector dwell, flags the final clock
// Rev 1.0
// ============================================================================
`default_nettype none

module dwell_counter
  import sweeper_pkg::*;
#(
  parameter int DWELL = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = cnt_width(DWELL);
  localparam logic [CW-1:0] LAST_VAL = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == LAST_VAL);

endmodule

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// ============================================================================
// truth_table_sweeper : drives every input vector for DWELL clocks and
// captures the circuit output into a truth table. Optional TT_CHECK_EN adds
// an expected-table compare (expected_tt / mismatch). Rev 1.0
// ============================================================================
`default_nettype none

module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter  int N_IN  = 3,
  parameter  int DWELL = 20,
  localparam int TT_W  = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            y,
`ifdef TT_CHECK_EN
  input  logic [TT_W-1:0] expected_tt,
  output logic            mismatch,
`endif
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            tt_valid,
  output logic [TT_W-1:0] truth_table
);

  localparam logic [N_IN-1:0] VEC_MAX = {N_IN{1'b1}};

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ttv_q, ttv_d;
  logic [TT_W-1:0] tt_q, tt_d;
  logic            cnt_clr, cnt_en, cnt_last;

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (cnt_last)
  );

  // Counter is parked at zero outside DRIVE so every sweep starts a fresh dwell.
  assign cnt_clr = (state_q == IDLE);
  assign cnt_en  = (state_q == DRIVE) && !abort;

`ifdef TT_CHECK_EN
  logic mm_q, mm_d;
`endif

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ttv_d   = ttv_q;
    tt_d    = tt_q;
`ifdef TT_CHECK_EN
    mm_d    = mm_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          vec_d   = '0;
          tt_d    = '0;
          ttv_d   = 1'b0;
          busy_d  = 1'b1;
`ifdef TT_CHECK_EN
          mm_d    = 1'b0;
`endif
        end
      end
      DRIVE: begin
        busy_d = 1'b1;
        if (abort) begin
          state_d = IDLE;
          vec_d   = '0;
          busy_d  = 1'b0;
          ttv_d   = 1'b0;
        end else if (cnt_last) begin
          tt_d[vec_q] = y;
          if (vec_q == VEC_MAX) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            ttv_d   = 1'b1;
`ifdef TT_CHECK_EN
            // Compare includes the bit sampled on this same edge.
            mm_d    = (tt_d != expected_tt);
`endif
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ttv_q   <= 1'b0;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ttv_q   <= ttv_d;
      tt_q    <= tt_d;
    end
  end

`ifdef TT_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mm_q <= 1'b0;
    end else begin
      mm_q <= mm_d;
    end
  end

  assign mismatch = mm_q;
`endif

  assign vec         = vec_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign tt_valid    = ttv_q;
  assign truth_table = tt_q;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// ============================================================================
// tb_truth_table_sweeper : directed and randomized sweeps of two instances
// (DWELL=20 and DWELL=1) against an arithmetic reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, abort_a, start_b, abort_b;
  logic [7:0] fn;
  logic [7:0] exp_tt;
  logic       sel;

  logic [2:0] vec_a, vec_b;
  logic       busy_a, busy_b, done_a, done_b, ttv_a, ttv_b;
  logic [7:0] tt_a, tt_b;
  logic       mm_a, mm_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Circuit under sweep: an arbitrary 3-input function given as its table.
  wire y_a = fn[vec_a];
  wire y_b = fn[vec_b];

  truth_table_sweeper #(.N_IN(3), .DWELL(20)) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .start       (start_a),
    .abort       (abort_a),
    .y           (y_a),
`ifdef TT_CHECK_EN
    .expected_tt (exp_tt),
    .mismatch    (mm_a),
`endif
    .vec         (vec_a),
    .busy        (busy_a),
    .done        (done_a),
    .tt_valid    (ttv_a),
    .truth_table (tt_a)
  );

  truth_table_sweeper #(.N_IN(3), .DWELL(1)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .start       (start_b),
    .abort       (abort_b),
    .y           (y_b),
`ifdef TT_CHECK_EN
    .expected_tt (exp_tt),
    .mismatch    (mm_b),
`endif
    .vec         (vec_b),
    .busy        (busy_b),
    .done        (done_b),
    .tt_valid    (ttv_b),
    .truth_table (tt_b)
  );

`ifndef TT_CHECK_EN
  assign mm_a = 1'b0;
  assign mm_b = 1'b0;
`endif

  wire [2:0] vec_s  = sel ? vec_b  : vec_a;
  wire       busy_s = sel ? busy_b : busy_a;
  wire       done_s = sel ? done_b : done_a;
  wire       ttv_s  = sel ? ttv_b  : ttv_a;
  wire [7:0] tt_s   = sel ? tt_b   : tt_a;
  wire       mm_s   = sel ? mm_b   : mm_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit b, input logic s, input logic a);
    if (b) begin
      start_b = s;
      abort_b = a;
    end else begin
      start_a = s;
      abort_a = a;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: after edge k of a sweep, vector k/D is on the bus; the table
  // completes on edge 8*D and done shows for exactly that cycle.
  task automatic run_sweep(input bit b, input logic [7:0] f, input int restart_k,
                           input int abort_k, input bit both);
    int d;
    int total;
    logic [7:0] part;
    d     = b ? 1 : 20;
    total = 8 * d;
    sel   = b;
    fn    = f;
    drive(b, 1'b1, both);
    tick();
    drive(b, 1'b0, 1'b0);
    chk("start", {busy_s, done_s, ttv_s, vec_s}, {3'b100, 3'd0});
    chk("start_clr", {mm_s, tt_s}, 9'd0);
    for (int k = 1; k <= total + 1; k++) begin
      drive(b, (k == restart_k), (k == abort_k));
      tick();
      drive(b, 1'b0, 1'b0);
      if (k == abort_k) begin
        part = 8'd0;
        for (int i = 0; i < 8; i++) begin
          if ((i + 1) * d < k) part[i] = f[i];
        end
        chk("abort_state", {busy_s, done_s, ttv_s, vec_s}, 6'd0);
        chk("abort_tt", tt_s, part);
        repeat (3) begin
          tick();
          chk("abort_no_done", {busy_s, done_s}, 2'b00);
        end
        return;
      end
      if (k < total) begin
        chk("drive", {busy_s, done_s, vec_s}, {2'b10, 3'(k / d)});
      end else if (k == total) begin
        chk("done", {busy_s, done_s, ttv_s, vec_s}, {3'b011, 3'd7});
        chk("tt", tt_s, f);
`ifdef TT_CHECK_EN
        chk("mismatch", mm_s, (f != exp_tt));
`endif
      end else begin
        chk("idle_after", {busy_s, done_s, ttv_s, vec_s}, {3'b001, 3'd7});
        chk("tt_hold", tt_s, f);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; abort_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0;
    fn = 8'h00;
    exp_tt = 8'hEA;
    sel = 1'b0;
    tick();
    tick();
    chk("reset_a", {busy_a, done_a, ttv_a, vec_a, tt_a, mm_a}, 15'd0);
    chk("reset_b", {busy_b, done_b, ttv_b, vec_b, tt_b, mm_b}, 15'd0);
    rst = 1'b0;
    tick();

    // (A&B)|C with DWELL=20, then A^B^C with DWELL=1
    run_sweep(1'b0, 8'hEA, -1, -1, 1'b0);
    run_sweep(1'b1, 8'h96, -1, -1, 1'b0);

    // abort in IDLE leaves the finished result alone
    sel = 1'b1;
    abort_b = 1'b1;
    tick();
    abort_b = 1'b0;
    chk("abort_idle", {busy_s, ttv_s, tt_s}, {2'b01, 8'h96});

    // abort during the vector-3 dwell, then a clean full sweep
    run_sweep(1'b0, 8'hEA, -1, 3 * 20 + 5, 1'b0);
    run_sweep(1'b0, 8'hEA, -1, -1, 1'b0);

    // reset during vector 5 with start held high alongside it
    sel = 1'b0;
    fn = 8'hEA;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (5 * 20 + 3) tick();
    chk("pre_rst_vec", vec_s, 3'd5);
    rst = 1'b1;
    start_a = 1'b1;
    tick();
    chk("rst_mid", {busy_s, done_s, ttv_s, vec_s, tt_s, mm_s}, 15'd0);
    rst = 1'b0;
    start_a = 1'b0;
    tick();
    chk("rst_start_ignored", {busy_s, vec_s}, 4'd0);

    // repeated start while busy, and start+abort together in IDLE
    run_sweep(1'b0, 8'hEA, 50, -1, 1'b0);
    run_sweep(1'b1, 8'($urandom), 3, -1, 1'b1);

    // A&B&C: table 8'h80, differs from the expected table
    run_sweep(1'b0, 8'h80, -1, -1, 1'b0);

    // randomized circuit functions
    repeat (4) run_sweep(1'b1, 8'($urandom), -1, -1, 1'b0);
    run_sweep(1'b0, 8'($urandom), -1, -1, 1'b0);
    run_sweep(1'b1, 8'($urandom), -1, int'($urandom_range(1, 8)), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
